// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//
// Purpose: bundles the core-side request/response handshake and the data
// memory / memory-mapped IO port of the load/store unit into one interface.
//
// Signals:
//   req_valid, req_write, req_funct3, req_addr, req_wdata  core request
//   busy, rdata_valid, rdata, fault                        core response
//   mem_address, mem_byteena, mem_data, mem_wren           memory request
//   mem_q                                                  memory read data
//
// Modports:
//   master  the load/store unit: it initiates every memory access
//   slave   the surrounding core and memory that the unit serves
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        fault;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
    output busy, rdata_valid, rdata, fault,
           mem_address, mem_byteena, mem_data, mem_wren
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_q,
    input  busy, rdata_valid, rdata, fault,
           mem_address, mem_byteena, mem_data, mem_wren
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: turns RV32I load/store requests from the execute stage into
// word-addressed memory accesses (byte enables, lane-replicated store data,
// write enable), waits out the read latency of the addressed region and
// returns an aligned, sign/zero-extended load result.
//
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-low reset
//   bus    load_store_unit_if.master: core request/response and memory port
//
// Parameters:
//   MEM_READ_LATENCY  read latency of RAM (word address bit 10 = 0)
//   IO_READ_LATENCY   read latency of IO reads (word address bit 10 = 1)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int IO_READ_LATENCY  = 2
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.master bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [3:0] MEM_CNT = 4'(MEM_READ_LATENCY - 1);
  localparam logic [3:0] IO_CNT  = 4'(IO_READ_LATENCY - 1);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        fault_q, fault_d;

  logic        req_legal_f3;
  logic        req_misaligned;
  logic        req_bad;
  logic [3:0]  st_byteena;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  // Byte-address bits above the 16 KiB window play no part in decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:14];

  // funct3 low bits encode the access size (00 byte, 01 half, 10 word),
  // so alignment only needs those two bits.
  always_comb begin
    if (bus.req_write) begin
      req_legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                     (bus.req_funct3 == 3'b010);
    end else begin
      req_legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                     (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                     (bus.req_funct3 == 3'b101);
    end
    req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_bad = !req_legal_f3 || req_misaligned;
  end

  // Store data is replicated across all lanes so the byte enables alone
  // pick which lane the memory actually writes.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_byteena = 4'b0001 << bus.req_addr[1:0];
        st_data    = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_byteena = 4'b0011 << {bus.req_addr[1], 1'b0};
        st_data    = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_byteena = 4'b1111;
        st_data    = bus.req_wdata;
      end
    endcase
  end

  // Lane selection uses the latched byte offset of the load in flight.
  always_comb begin
    ld_byte = bus.mem_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.mem_q[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = bus.mem_q;
    endcase
  end

  // Memory port: in WAIT the latched address is replayed because the IO
  // read mux keys off the live address bit 10; in IDLE a request goes
  // straight through so the memory captures it on the request edge.
  always_comb begin
    bus.mem_address = 12'd0;
    bus.mem_byteena = 4'b0000;
    bus.mem_data    = 32'd0;
    bus.mem_wren    = 1'b0;
    if (state_q == WAIT) begin
      bus.mem_address = addr_q[13:2];
      bus.mem_byteena = 4'b1111;
    end else if (bus.req_valid) begin
      bus.mem_address = bus.req_addr[13:2];
      bus.mem_byteena = bus.req_write ? st_byteena : 4'b1111;
      bus.mem_data    = bus.req_write ? st_data : 32'd0;
      bus.mem_wren    = bus.req_write && !req_bad && reset;
    end
  end

  // Request acceptance and load wait sequencing. Stores and faulting
  // requests complete in IDLE; only legal loads enter WAIT.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    funct3_d      = funct3_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req_valid) begin
        if (req_bad) begin
          fault_d = 1'b1;
        end else if (!bus.req_write) begin
          addr_d   = bus.req_addr[13:0];
          funct3_d = bus.req_funct3;
          cnt_d    = bus.req_addr[12] ? IO_CNT : MEM_CNT;
          state_d  = WAIT;
        end
      end
    end else begin
      if (cnt_q == 4'd0) begin
        rdata_d       = ld_result;
        rdata_valid_d = 1'b1;
        state_d       = IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // Reset abandons any load in flight without producing a result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= 14'd0;
      funct3_q      <= 3'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.busy        = (state_q == WAIT);
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose: directed, self-checking bench for load_store_unit. The bench
// plays both the core (request side) and the memory (drives mem_q in the
// cycle the data would be valid). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic clock;
  logic reset;
  int   num_checks;
  int   num_errors;

  load_store_unit_if bus_if ();

  load_store_unit #(
    .MEM_READ_LATENCY(1),
    .IO_READ_LATENCY (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus_if.req_valid  = valid;
    bus_if.req_write  = write;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Issue a load, model the memory (wrong data until the last wait cycle),
  // and check busy duration, held address and the returned result.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [11:0] exp_word, input logic [31:0] qval,
                         input int waits, input logic [31:0] exp_rdata);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'd0);
    #1;
    checkOutput({tag, "_req_wren"}, {31'd0, bus_if.mem_wren}, 32'd0);
    checkOutput({tag, "_req_be"}, {28'd0, bus_if.mem_byteena}, 32'hF);
    checkOutput({tag, "_req_addr"}, {20'd0, bus_if.mem_address}, {20'd0, exp_word});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    for (int i = 0; i < waits; i++) begin
      bus_if.mem_q = (i == waits - 1) ? qval : ~qval;
      #1;
      checkOutput({tag, "_wait_busy"}, {31'd0, bus_if.busy}, 32'd1);
      checkOutput({tag, "_wait_addr"}, {20'd0, bus_if.mem_address}, {20'd0, exp_word});
      checkOutput({tag, "_wait_valid"}, {31'd0, bus_if.rdata_valid}, 32'd0);
      nextCycle();
    end
    bus_if.mem_q = 32'd0;
    checkOutput({tag, "_rvalid"}, {31'd0, bus_if.rdata_valid}, 32'd1);
    checkOutput({tag, "_rdata"}, bus_if.rdata, exp_rdata);
    checkOutput({tag, "_busy_done"}, {31'd0, bus_if.busy}, 32'd0);
    nextCycle();
    checkOutput({tag, "_rvalid_pulse"}, {31'd0, bus_if.rdata_valid}, 32'd0);
    checkOutput({tag, "_rdata_hold"}, bus_if.rdata, exp_rdata);
  endtask

  // Illegal or misaligned request: no write, no busy, one-cycle fault.
  task automatic runFault(input string tag, input logic write, input logic [2:0] f3,
                          input logic [31:0] addr);
    applyStimulus(1'b1, write, f3, addr, 32'h12345678);
    #1;
    checkOutput({tag, "_wren"}, {31'd0, bus_if.mem_wren}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput({tag, "_fault"}, {31'd0, bus_if.fault}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    nextCycle();
    checkOutput({tag, "_fault_pulse"}, {31'd0, bus_if.fault}, 32'd0);
  endtask

  // Store: combinational memory outputs in the request cycle.
  task automatic runStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [11:0] exp_word,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b1, f3, addr, wdata);
    #1;
    checkOutput({tag, "_addr"}, {20'd0, bus_if.mem_address}, {20'd0, exp_word});
    checkOutput({tag, "_be"}, {28'd0, bus_if.mem_byteena}, {28'd0, exp_be});
    checkOutput({tag, "_data"}, bus_if.mem_data, exp_data);
    checkOutput({tag, "_wren"}, {31'd0, bus_if.mem_wren}, 32'd1);
    checkOutput({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    nextCycle();
  endtask

  // Safety net: the sequence below is fixed-length, this only guards a hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    num_checks   = 0;
    num_errors   = 0;
    reset        = 1'b0;
    bus_if.mem_q = 32'd0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) nextCycle();

    // Reset state.
    checkOutput("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, bus_if.rdata_valid}, 32'd0);
    checkOutput("rst_fault", {31'd0, bus_if.fault}, 32'd0);
    checkOutput("rst_rdata", bus_if.rdata, 32'd0);
    checkOutput("rst_wren", {31'd0, bus_if.mem_wren}, 32'd0);
    checkOutput("rst_be", {28'd0, bus_if.mem_byteena}, 32'd0);
    checkOutput("rst_addr", {20'd0, bus_if.mem_address}, 32'd0);
    checkOutput("rst_data", bus_if.mem_data, 32'd0);
    reset = 1'b1;
    nextCycle();

    // Back-to-back stores, then a RAM byte load from the stored lane.
    runStore("sw", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 12'h004, 4'b1111, 32'hDEAD_BEEF);
    runStore("sb", 3'b000, 32'h0000_0013, 32'h0000_00A5, 12'h004, 4'b1000, 32'hA5A5_A5A5);
    runStore("sh", 3'b001, 32'h0000_0006, 32'h0000_BEEF, 12'h001, 4'b1100, 32'hBEEF_BEEF);
    runStore("sw_hiaddr", 3'b010, 32'hFFFF_0010, 32'h0102_0304, 12'h004, 4'b1111, 32'h0102_0304);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput("idle_wren", {31'd0, bus_if.mem_wren}, 32'd0);
    checkOutput("idle_be", {28'd0, bus_if.mem_byteena}, 32'd0);
    checkOutput("st_no_fault", {31'd0, bus_if.fault}, 32'd0);
    nextCycle();

    runLoad("lb", 3'b000, 32'h0000_0013, 12'h004, 32'hA500_0000, 1, 32'hFFFF_FFA5);
    runLoad("lhu", 3'b101, 32'h0000_0022, 12'h008, 32'h8001_1234, 1, 32'h0000_8001);
    runLoad("lh", 3'b001, 32'h0000_0022, 12'h008, 32'h8001_1234, 1, 32'hFFFF_8001);
    runLoad("lw", 3'b010, 32'h0000_0020, 12'h008, 32'h8001_1234, 1, 32'h8001_1234);
    runLoad("lbu", 3'b100, 32'h0000_0021, 12'h008, 32'h8001_1234, 1, 32'h0000_0012);
    runLoad("lh_lo", 3'b001, 32'h0000_0020, 12'h008, 32'h0000_F00D, 1, 32'hFFFF_F00D);
    runLoad("io_lw", 3'b010, 32'h0000_1000, 12'h400, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
    runLoad("io_lb", 3'b000, 32'h0000_1002, 12'h400, 32'h0080_0000, 2, 32'hFFFF_FF80);

    // Store held during WAIT is ignored, then accepted as busy falls.
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
    bus_if.mem_q = 32'hA500_0000;
    #1;
    checkOutput("held_busy", {31'd0, bus_if.busy}, 32'd1);
    checkOutput("held_wren", {31'd0, bus_if.mem_wren}, 32'd0);
    checkOutput("held_addr", {20'd0, bus_if.mem_address}, 32'h004);
    nextCycle();
    bus_if.mem_q = 32'd0;
    checkOutput("held_rvalid", {31'd0, bus_if.rdata_valid}, 32'd1);
    checkOutput("held_rdata", bus_if.rdata, 32'hFFFF_FFA5);
    checkOutput("held_accept_wren", {31'd0, bus_if.mem_wren}, 32'd1);
    checkOutput("held_accept_addr", {20'd0, bus_if.mem_address}, 32'h010);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput("held_after_busy", {31'd0, bus_if.busy}, 32'd0);
    nextCycle();

    // Faulting requests.
    runFault("lw_mis", 1'b0, 3'b010, 32'h0000_0002);
    runFault("sh_mis", 1'b1, 3'b001, 32'h0000_0005);
    runFault("ld_f3_011", 1'b0, 3'b011, 32'h0000_0000);
    runFault("st_f3_100", 1'b1, 3'b100, 32'h0000_0000);
    runFault("lhu_mis", 1'b0, 3'b101, 32'h0000_0003);

    // Reset during the first WAIT cycle of an IO load aborts it.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy_pre", {31'd0, bus_if.busy}, 32'd1);
    nextCycle();
    reset = 1'b1;
    bus_if.mem_q = 32'h5555_5555;
    #1;
    checkOutput("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("abort_rvalid", {31'd0, bus_if.rdata_valid}, 32'd0);
    checkOutput("abort_rdata", bus_if.rdata, 32'd0);
    nextCycle();
    checkOutput("abort_rvalid2", {31'd0, bus_if.rdata_valid}, 32'd0);
    checkOutput("abort_busy2", {31'd0, bus_if.busy}, 32'd0);
    bus_if.mem_q = 32'd0;
    runStore("post_sw", 3'b010, 32'h0000_0008, 32'h1122_3344, 12'h002, 4'b1111, 32'h1122_3344);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput("post_sw_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("post_sw_fault", {31'd0, bus_if.fault}, 32'd0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the data memory / memory-mapped IO port: converts RV32I load/store requests into word address, byte enables, replicated write data and write enable.
- Waits the read latency of the addressed region, holding the address stable, then returns an aligned and extended load result.
- Sits between the execute stage and the data memory; it is the only driver of the memory port.

Parameters:
- MEM_READ_LATENCY, 1, cycles from request edge to valid mem_q for RAM addresses (word address bit 10 = 0)
- IO_READ_LATENCY, 2, cycles from request edge to valid mem_q for IO-read addresses (word address bit 10 = 1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  core request strobe, sampled in IDLE only
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- busy  out  1  load in flight; core stalls
- rdata_valid  out  1  one-cycle pulse, rdata valid
- rdata  out  32  extended load result
- fault  out  1  one-cycle pulse: misaligned or illegal funct3
- mem_address  out  12  word address = req_addr[13:2]; bit 11 = IO write, bit 10 = IO read
- mem_byteena  out  4  byte enables
- mem_data  out  32  lane-replicated write data
- mem_wren  out  1  write enable
- mem_q  in  32  read data from memory/IO

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state = IDLE; busy, rdata_valid, fault = 0; rdata = 0.
  - Memory outputs are 0 in IDLE with no request.
- FSM states: IDLE, WAIT.
- IDLE, req_valid = 1: memory outputs are driven combinationally from req_*, so the memory input registers capture them at the same edge.
- Alignment rules:
  - H/HU requires req_addr[0] = 0.
  - W requires req_addr[1:0] = 0.
  - Store funct3 must be in {000, 001, 010}; load funct3 must be in {000, 001, 010, 100, 101}.
  - A violation gives mem_wren = 0, no state change, and fault = 1 in the next cycle.
- Store (legal):
  - mem_wren = 1 for exactly that cycle.
  - SB: byteena = 0001 << addr[1:0], data = {4{wdata[7:0]}}.
  - SH: byteena = 0011 << {addr[1], 0}, data = {2{wdata[15:0]}}.
  - SW: byteena = 1111, data = wdata.
  - busy stays 0. Back-to-back stores are accepted every cycle.
- Load (legal):
  - byteena = 1111, mem_wren = 0.
  - Latch addr[13:0] and funct3; load counter = (addr[12] ? IO_READ_LATENCY : MEM_READ_LATENCY) - 1; go to WAIT.
- WAIT:
  - busy = 1.
  - mem_address is held at the latched value, because the memory's read mux uses the live address bit 10.
  - mem_wren = 0, byteena = 1111.
  - Counter decrements each cycle. While counter = 0, mem_q is valid.
  - At that edge, register rdata and pulse rdata_valid = 1 for one cycle; return to IDLE.
- Extraction uses latched addr[1:0]:
  - byte = mem_q[8*addr[1:0] +: 8]; half = mem_q[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes mem_q unchanged.
- Latency: RAM load result is valid 2 cycles after the request edge; IO load result 3 cycles after. busy is high for 1 and 2 cycles respectively.
- Outside a completing load, rdata holds its last value.
- req_valid while busy is ignored; the core must hold the request until busy falls.
- A new request is accepted in the same cycle rdata_valid is high (state is IDLE).
- Reset asserted during WAIT aborts the load: no rdata_valid and no memory write; the next cycle is IDLE.
- Address bits above 13 are ignored (no decode fault).

Test Plan:
- Reset, then SW addr 0x0000_0010, wdata 0xDEADBEEF -> same cycle: mem_address 0x004, byteena 1111, data 0xDEADBEEF, wren 1; busy stays 0.
- SB addr 0x13, wdata 0x000000A5 -> byteena 1000, data 0xA5A5A5A5. Follow with LB addr 0x13 on RAM returning 0xA5000000 -> rdata 0xFFFFFFA5, rdata_valid 2 cycles after request, busy high 1 cycle.
- LHU addr 0x22 with mem_q 0x8001_1234 -> rdata 0x00008001. LH of the same -> 0xFFFF8001. LW -> 0x80011234.
- Load from IO addr 0x1000 (word address 0x400) -> busy high 2 cycles, mem_address held at 0x400 throughout, rdata = mem_q sampled on the second wait cycle.
- LW addr 0x02, SH addr 0x05, funct3 011 load -> each gives wren 0, no busy, one-cycle fault pulse the next cycle.
- Start IO load, drop reset to 0 in the first WAIT cycle -> busy 0 and no rdata_valid afterwards; a subsequent SW completes normally.
